// File: rtl/ram_tdp_arbiter.sv
// Round-robin arbiter that shares both ports of a true-dual-port CS/OE RAM among NREQ requesters.
// Up to two grants per cycle; read data returns to its owner three cycles after the handshake.
module ram_tdp_arbiter #(
    parameter int NREQ   = 4,
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ*DWIDTH-1:0] rsp_rdata,
    output logic                   cs_0,
    output logic                   cs_1,
    output logic                   oe_0,
    output logic                   oe_1,
    output logic [AWIDTH-1:0]      addr_0,
    output logic [AWIDTH-1:0]      addr_1,
    output logic [DWIDTH-1:0]      din_0,
    output logic [DWIDTH-1:0]      din_1,
    input  logic [DWIDTH-1:0]      dout_0,
    input  logic [DWIDTH-1:0]      dout_1
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     g0_idx;
    logic [IW-1:0]     g1_idx;
    logic [IW-1:0]     scan_idx;
    logic              g0_found;
    logic              g1_found;
    logic              g1_ok;
    logic              conflict;
    logic [NREQ-1:0]   grant;
    logic [AWIDTH-1:0] g0_addr;
    logic [AWIDTH-1:0] g1_addr;

    logic              t1_rd_0, t1_rd_1, t2_rd_0, t2_rd_1;
    logic [IW-1:0]     t1_own_0, t1_own_1, t2_own_0, t2_own_1;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        g0_found = 1'b0;
        g1_found = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[scan_idx]) begin
                if (!g0_found) begin
                    g0_found = 1'b1;
                    g0_idx   = scan_idx;
                end else if (!g1_found) begin
                    g1_found = 1'b1;
                    g1_idx   = scan_idx;
                end
            end
        end
    end

    // A second access to the same address is only safe when both are reads.
    assign g0_addr  = req_addr[g0_idx*AWIDTH +: AWIDTH];
    assign g1_addr  = req_addr[g1_idx*AWIDTH +: AWIDTH];
    assign conflict = (g0_addr == g1_addr) && (req_wr[g0_idx] || req_wr[g1_idx]);
    assign g1_ok    = g1_found && !conflict;

    always_comb begin
        grant = '0;
        if (g0_found) grant[g0_idx] = 1'b1;
        if (g1_ok)    grant[g1_idx] = 1'b1;
    end

    // Gated by reset so no handshake is advertised while the pipeline is held clear.
    assign req_ready = reset ? grant : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            cs_0      <= 1'b0;
            cs_1      <= 1'b0;
            oe_0      <= 1'b0;
            oe_1      <= 1'b0;
            addr_0    <= '0;
            addr_1    <= '0;
            din_0     <= '0;
            din_1     <= '0;
            t1_rd_0   <= 1'b0;
            t1_rd_1   <= 1'b0;
            t2_rd_0   <= 1'b0;
            t2_rd_1   <= 1'b0;
            t1_own_0  <= '0;
            t1_own_1  <= '0;
            t2_own_0  <= '0;
            t2_own_1  <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            if (g1_ok) begin
                rr_ptr <= next_idx(g1_idx);
            end else if (g0_found) begin
                rr_ptr <= next_idx(g0_idx);
            end

            cs_0 <= g0_found;
            if (g0_found) begin
                oe_0   <= ~req_wr[g0_idx];
                addr_0 <= g0_addr;
                din_0  <= req_wdata[g0_idx*DWIDTH +: DWIDTH];
            end
            cs_1 <= g1_ok;
            if (g1_ok) begin
                oe_1   <= ~req_wr[g1_idx];
                addr_1 <= g1_addr;
                din_1  <= req_wdata[g1_idx*DWIDTH +: DWIDTH];
            end

            t1_rd_0  <= g0_found && !req_wr[g0_idx];
            t1_rd_1  <= g1_ok && !req_wr[g1_idx];
            t1_own_0 <= g0_idx;
            t1_own_1 <= g1_idx;
            t2_rd_0  <= t1_rd_0;
            t2_rd_1  <= t1_rd_1;
            t2_own_0 <= t1_own_0;
            t2_own_1 <= t1_own_1;

            rsp_valid <= '0;
            if (t2_rd_0) begin
                rsp_valid[t2_own_0]                   <= 1'b1;
                rsp_rdata[t2_own_0*DWIDTH +: DWIDTH] <= dout_0;
            end
            if (t2_rd_1) begin
                rsp_valid[t2_own_1]                   <= 1'b1;
                rsp_rdata[t2_own_1*DWIDTH +: DWIDTH] <= dout_1;
            end
        end
    end
endmodule
